// File: rtl/result_packer.sv
// Packs RATIO narrow result words into one OUT_W word, little-endian slot order,
// with valid/ready on both sides and a flush that emits a partially filled group.
module result_packer #(
    parameter  int IN_W  = 10,
    parameter  int RATIO = 3,
    parameter  int CNT_W = 16,
    localparam int OUT_W = IN_W * RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
    output logic [CNT_W-1:0] word_count
);

    localparam int SLOT_W = $clog2(RATIO);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(RATIO - 1);

    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic [RATIO-1:0]  keep;
    logic [RATIO-1:0]  keep_next;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_next;
    logic              flush_pending;
    logic              out_free;
    logic              beat;
    logic              complete;
    logic              emit_partial;
    logic              load;

    always_comb begin
        in_ready = !rst && !flush_pending && !(slot == LAST && out_valid && !out_ready);
    end

    always_comb begin
        out_free  = !out_valid || out_ready;
        beat      = in_valid && in_ready;
        complete  = beat && (slot == LAST);
        acc_next  = acc;
        keep_next = keep;
        slot_next = slot;
        if (beat) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (slot == SLOT_W'(i)) begin
                    acc_next[i*IN_W +: IN_W] = in_data;
                    keep_next[i]             = 1'b1;
                end
            end
            slot_next = slot + SLOT_W'(1);
        end
        // A same-cycle beat counts toward the partial group, so a flush with
        // slot 0 and a beat still emits a one-slot word.
        emit_partial = !complete && (flush || flush_pending) && (beat || slot != '0);
        load         = complete || (emit_partial && out_free);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            keep          <= '0;
            slot          <= '0;
            flush_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_keep      <= '0;
            word_count    <= '0;
        end else begin
            if (load) begin
                out_data      <= acc_next;
                out_keep      <= keep_next;
                out_valid     <= 1'b1;
                acc           <= '0;
                keep          <= '0;
                slot          <= '0;
                flush_pending <= 1'b0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                acc  <= acc_next;
                keep <= keep_next;
                slot <= slot_next;
                if (emit_partial) begin
                    flush_pending <= 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: expected packed words are queued as beats are
// driven and popped by a monitor on each output handshake.
module tb_result_packer;

    localparam int IN_W  = 10;
    localparam int RATIO = 3;
    localparam int CNT_W = 16;
    localparam int OUT_W = IN_W * RATIO;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic [CNT_W-1:0] word_count;

    int checks   = 0;
    int failures = 0;

    word_t            sb[$];
    logic [OUT_W-1:0] m_acc;
    logic [RATIO-1:0] m_keep;
    int               m_slot;
    int               m_count;

    result_packer #(
        .IN_W (IN_W),
        .RATIO(RATIO),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc  = '0;
        m_keep = '0;
        m_slot = 0;
    endtask

    task automatic model_accept(input logic [IN_W-1:0] d, input logic fl);
        m_acc[m_slot*IN_W +: IN_W] = d;
        m_keep[m_slot]             = 1'b1;
        m_slot++;
        if (m_slot == RATIO || fl) begin
            sb.push_back({m_acc, m_keep});
            model_clear();
        end
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic fl);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(negedge clk);
        chk("in_ready_on_beat", in_ready, 1);
        tick();
        model_accept(d, fl);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (m_slot != 0) begin
            sb.push_back({m_acc, m_keep});
            model_clear();
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            tick();
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        sb.delete();
        model_clear();
        m_count = 0;
        rst     = 1'b0;
    endtask

    // Output monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL extra_word observed=%h expected=no_word", out_data);
            end
            if (sb.size() > 0) begin
                word_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_keep", out_keep, e.keep);
            end
            m_count++;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        model_clear();
        m_count = 0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_keep", out_keep, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // full group
        send(10'h001, 1'b0);
        send(10'h002, 1'b0);
        send(10'h003, 1'b0);
        chk("full_latency_valid", out_valid, 1);
        chk("full_data_const", out_data, 30'h00300801);
        drain();
        chk("full_word_count", word_count, m_count % 65536);
        chk("full_word_count_1", m_count, 1);

        // backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(IN_W'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 10'h006;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready_stall", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 30'h00300801);
            chk("bp_hold_keep", out_keep, 3'b111);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", in_ready, 1);
        tick();
        model_accept(10'h006, 1'b0);
        in_valid = 1'b0;
        chk("bp_second_word", out_data, 30'h00601404);
        drain();

        // partial flush
        send(10'h3FF, 1'b0);
        send(10'h155, 1'b0);
        do_flush();
        chk("partial_data_const", out_data, 30'h000557FF);
        chk("partial_keep_const", out_keep, 3'b011);
        drain();
        repeat (3) tick();
        chk("partial_word_count", word_count, m_count % 65536);

        // flush coincident with completing beat, then an empty flush
        send(10'h001, 1'b0);
        send(10'h002, 1'b0);
        send(10'h003, 1'b1);
        drain();
        do_flush();
        repeat (4) tick();
        chk("empty_flush_valid", out_valid, 0);
        chk("coincident_word_count", word_count, m_count % 65536);

        // deferred flush
        out_ready = 1'b0;
        send(10'h001, 1'b0);
        send(10'h002, 1'b0);
        send(10'h003, 1'b0);
        send(10'h007, 1'b0);
        do_flush();
        chk("deferred_in_ready_0", in_ready, 0);
        tick();
        chk("deferred_in_ready_hold", in_ready, 0);
        chk("deferred_hold_data", out_data, 30'h00300801);
        out_ready = 1'b1;
        drain();
        chk("deferred_in_ready_back", in_ready, 1);
        chk("deferred_word_count", word_count, m_count % 65536);

        // reset mid-group
        send(10'h005, 1'b0);
        send(10'h006, 1'b0);
        do_reset();
        chk("midrst_word_count_0", word_count, 0);
        chk("midrst_out_valid", out_valid, 0);
        send(10'h00A, 1'b0);
        send(10'h00B, 1'b0);
        send(10'h00C, 1'b0);
        chk("midrst_data_const", out_data, 30'h00C02C0A);
        drain();
        chk("midrst_word_count_1", word_count, 1);

        // word_count wrap: one single-slot flushed word per cycle
        do_reset();
        for (int i = 0; i < 65535; i++) send(IN_W'(i), 1'b1);
        drain();
        chk("wrap_count_ffff", word_count, 16'hFFFF);
        send(10'h3AB, 1'b1);
        drain();
        chk("wrap_count_0", word_count, 0);

        chk("final_queue_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
